seq_gen_1101: RTL and testbench

Serial pattern transmitter that drives a programmable number of `1101` frames onto a one-bit line, MSB first. Frames are optionally separated by idle zero gaps or packed with overlap. It is the stimulus end of the team's overlapping 1101 sequence detector. It sits upstream of the detector in loopback benches and on-chip self-test paths.

---
 rtl/seq_gen_1101_pkg.sv | 14 +
 rtl/seq_gen_1101.sv | 130 +++++++++++++
 tb/tb_seq_gen_1101.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_1101_pkg.sv
// Shared definitions for the 1101 pattern transmitter and its detector:
// FSM encoding and the default frame pattern both ends agree on.
package seq_gen_1101_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int         PAT_W_DEFAULT = 4;
  localparam logic [3:0] PAT_DEFAULT   = 4'b1101;

endpackage

// File: rtl/seq_gen_1101.sv
// Serial transmitter of a programmable burst of pattern frames, MSB first,
// with optional zero gaps between frames or overlap of a shared end bit.
module seq_gen_1101
  import seq_gen_1101_pkg::*;
#(
  parameter int               PAT_W = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PAT   = PAT_DEFAULT,
  parameter int               CNT_W = 8,
  parameter int               GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             ovl,
  input  logic             en,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent,
  output state_t           dbg_state
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 2);

  // Handshake: a bit on out is offered while valid=1 and is consumed on
  // each rising edge where en=1; with en=0 everything holds.

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gcnt;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             ovl_q;
  logic             eff_ovl;

  // Overlap only makes sense when the pattern's last bit can double as the
  // first bit of the next frame, and only without idle gaps.
  assign eff_ovl   = ovl_q && (gap_q == '0) && (PAT[PAT_W-1] == PAT[0]);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      gcnt  <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      ovl_q <= 1'b0;
      out   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sent  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sent <= '0;
            if (count != '0) begin
              cnt_q <= count;
              gap_q <= gap;
              ovl_q <= ovl;
              idx   <= IDX_TOP;
              out   <= PAT[PAT_W-1];
              valid <= 1'b1;
              busy  <= 1'b1;
              state <= S_SEND;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (en) begin
            if (idx != '0) begin
              idx <= idx - 1'b1;
              out <= PAT[idx - 1'b1];
            end else begin
              sent <= sent + CNT_W'(1);
              if (sent + CNT_W'(1) == cnt_q) begin
                out   <= 1'b0;
                valid <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else if (eff_ovl) begin
                idx <= IDX_OVL;
                out <= PAT[PAT_W-2];
              end else if (gap_q != '0) begin
                gcnt  <= gap_q;
                out   <= 1'b0;
                state <= S_GAP;
              end else begin
                idx <= IDX_TOP;
                out <= PAT[PAT_W-1];
              end
            end
          end
        end

        S_GAP: begin
          if (en) begin
            if (gcnt == GAP_W'(1)) begin
              idx   <= IDX_TOP;
              out   <= PAT[PAT_W-1];
              state <= S_SEND;
            end else begin
              gcnt <= gcnt - 1'b1;
            end
          end
        end

        default: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_1101.sv
// Directed bench for seq_gen_1101: bursts are checked bit by bit against a
// queue built from the 1101 frame model, plus reset and zero-count corners.
module tb_seq_gen_1101;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic [3:0] gap;
  logic       ovl;
  logic       en;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
  logic [7:0] sent;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  // Expected entry: {is_gap_bit, last_bit_of_frame, line_bit}
  logic [2:0] exp_q[$];

  seq_gen_1101 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .gap       (gap),
    .ovl       (ovl),
    .en        (en),
    .out       (out),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .sent      (sent),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out"},   {31'd0, out},   32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // Frame model: 1101 MSB first, shared end bit in overlap, zero gaps otherwise.
  task automatic build_expected(input int cnt, input int g, input int o);
    logic [3:0] pat;
    int         first;
    pat = 4'b1101;
    exp_q.delete();
    for (int f = 0; f < cnt; f++) begin
      first = (o != 0 && g == 0 && f > 0) ? 2 : 3;
      for (int b = first; b >= 0; b--) exp_q.push_back({1'b0, (b == 0), pat[b]});
      if (f < cnt - 1 && !(o != 0 && g == 0))
        for (int z = 0; z < g; z++) exp_q.push_back(3'b100);
    end
  endtask

  // driver: issue a burst and follow it to its done pulse.
  // en_mode 0 = en held high, 1 = en follows 1,0,0,1 and start is pulsed mid-burst.
  task automatic run_burst(input string tag, input int cnt, input int g, input int o,
                           input int en_mode);
    int         exp_bits;
    int         nbits;
    int         ndone;
    int         done_cyc;
    int         model_sent;
    int         det;
    logic [3:0] sh;
    logic       en_pat[4];
    logic [2:0] head;
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    build_expected(cnt, g, o);
    exp_bits   = exp_q.size();
    nbits      = 0;
    ndone      = 0;
    done_cyc   = 0;
    model_sent = 0;
    det        = 0;
    sh         = 4'd0;

    start = 1'b1;
    count = 8'(cnt);
    gap   = 4'(g);
    ovl   = o[0];
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count = 8'($urandom_range(1, 200));
    gap   = 4'($urandom_range(0, 15));
    ovl   = 1'($urandom_range(0, 1));

    for (int cyc = 1; cyc < 300; cyc++) begin
      if (done) begin
        ndone++;
        done_cyc = cyc;
        break;
      end
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_busy"},  {31'd0, busy},  32'd1);
      check({tag, "_sent"},  {24'd0, sent},  32'(model_sent));
      if (exp_q.size() == 0) begin
        check({tag, "_extra_bit"}, 32'(nbits + 1), 32'(exp_bits));
        break;
      end
      head = exp_q[0];
      check({tag, "_bit"},   {31'd0, out},       {31'd0, head[0]});
      check({tag, "_state"}, {30'd0, dbg_state}, head[2] ? 32'd2 : 32'd1);
      en = (en_mode == 0) ? 1'b1 : en_pat[(cyc - 1) % 4];
      start = (en_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (en) begin
        void'(exp_q.pop_front());
        nbits++;
        sh = {sh[2:0], head[0]};
        if (nbits >= 4 && sh == 4'b1101) det++;
        if (head[1]) model_sent++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    en    = 1'b1;

    check({tag, "_done_seen"}, 32'(ndone), 32'd1);
    check({tag, "_nbits"},     32'(nbits), 32'(exp_bits));
    check({tag, "_detects"},   32'(det),   32'(cnt));
    check({tag, "_sent_end"},  {24'd0, sent}, 32'(cnt));
    if (en_mode == 0) check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_bits + 1));
    check_idle_outputs({tag, "_end"});
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_sent_hold"}, {24'd0, sent}, 32'(cnt));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b1;
    count = 8'd3;
    gap   = 4'd0;
    ovl   = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    // reset wins over a simultaneous start
    check_idle_outputs("reset");
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sent", {24'd0, sent}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_burst("single",   1, 0, 0, 0);
    run_burst("gap2",     3, 2, 0, 0);
    run_burst("overlap",  3, 0, 1, 0);
    run_burst("ovl_gap",  2, 2, 1, 0);
    run_burst("en_tog",   2, 0, 0, 1);
    run_burst("gap1_tog", 2, 1, 0, 1);

    // zero-count start: only a done pulse, sent cleared
    start = 1'b1;
    count = 8'd0;
    gap   = 4'd3;
    ovl   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_sent", {24'd0, sent}, 32'd0);
    check_idle_outputs("zero");
    @(negedge clk);
    check("zero_done_1cyc", {31'd0, done}, 32'd0);
    check("zero_valid", {31'd0, valid}, 32'd0);

    // reset while the sixth bit of a 4-frame burst is on the line
    start = 1'b1;
    count = 8'd4;
    gap   = 4'd0;
    ovl   = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_bit6", {31'd0, out}, 32'd1);
    check("mid_sent", {24'd0, sent}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_reset");
    check("mid_reset_done", {31'd0, done}, 32'd0);
    check("mid_reset_sent", {24'd0, sent}, 32'd0);
    @(negedge clk);
    check("mid_reset_done2", {31'd0, done}, 32'd0);
    run_burst("after_rst", 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
